// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: ALUcontrol codes, ALUOp, funct fields and FSM states.
// Optional divider is enabled by defining EX_ALU_DIV_EN.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_NOP   = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and, with EX_ALU_DIV_EN, restoring divide.
// WIDTH iterations after acceptance; hi/lo update on the last one, then one DONE cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_mul_i,
`ifdef EX_ALU_DIV_EN
  input  logic             start_div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             idle_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH:0]   mul_sum;
  logic             last;

`ifdef EX_ALU_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
`endif

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // {acc_q, q_q} is the double-width working register for both operations.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
    acc_d   = mul_sum[WIDTH:1];
    q_d     = {mul_sum[0], q_q[WIDTH-1:1]};
`ifdef EX_ALU_DIV_EN
    div_sh   = {acc_q, q_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (state_q == ST_DIV) begin
      if (!div_diff[WIDTH]) begin
        acc_d = div_diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_sh[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_mul_i) begin
            state_q <= ST_MUL;
            q_q     <= a_i;
            b_q     <= b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
`ifdef EX_ALU_DIV_EN
          else if (start_div_i) begin
            state_q <= ST_DIV;
            q_q     <= a_i;
            b_q     <= b_i;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
`endif
        end
        ST_MUL, ST_DIV: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_q    <= acc_d;
            lo_q    <= q_d;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle_o = (state_q == ST_IDLE);
  assign busy_o = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_alu_unit.sv
// EX-stage ALU: combinational decode/datapath plus iterative multu/divu (divu with EX_ALU_DIV_EN).
// stall is high from the accept cycle through the last iteration; held instruction is not relaunched.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       ALUcontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic       md_idle, md_busy;
  logic       start_mul;
  logic       start_div;
  logic [5:0] sh_amt;
  logic       slt_bit;

  always_comb begin
    ALUcontrol = ALU_NOP;
    case (ALUOp)
      ALUOP_ADD: ALUcontrol = ALU_ADD;
      ALUOP_SUB: ALUcontrol = ALU_SUB;
      ALUOP_AND: ALUcontrol = ALU_AND;
      default: begin
        case (funct)
          F_ADD:   ALUcontrol = ALU_ADD;
          F_SUB:   ALUcontrol = ALU_SUB;
          F_AND:   ALUcontrol = ALU_AND;
          F_OR:    ALUcontrol = ALU_OR;
          F_SLT:   ALUcontrol = ALU_SLT;
          F_NOR:   ALUcontrol = ALU_NOR;
          F_SLL:   ALUcontrol = ALU_SLL;
          F_SRL:   ALUcontrol = ALU_SRL;
          F_MFHI:  ALUcontrol = ALU_MFHI;
          F_MFLO:  ALUcontrol = ALU_MFLO;
          F_MULTU: ALUcontrol = ALU_MULTU;
`ifdef EX_ALU_DIV_EN
          F_DIVU:  ALUcontrol = ALU_DIVU;
`endif
          default: ALUcontrol = ALU_NOP;
        endcase
      end
    endcase
  end

  // Narrow datapaths clamp the shift so it never exceeds WIDTH-1.
  always_comb begin
    sh_amt = {1'b0, shamt};
    if (sh_amt > 6'(WIDTH - 1)) sh_amt = 6'(WIDTH - 1);
  end

  assign slt_bit = ($signed(op_a) < $signed(op_b));

  always_comb begin
    result = '0;
    case (ALUcontrol)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_NOR:  result = ~(op_a | op_b);
      ALU_SLL:  result = op_b << sh_amt;
      ALU_SRL:  result = op_b >> sh_amt;
      ALU_MFHI: result = hi;
      ALU_MFLO: result = lo;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

  // rst gates start so stall drops immediately on an asynchronous reset.
  assign start_mul = in_valid & ~rst & md_idle & (ALUcontrol == ALU_MULTU);
`ifdef EX_ALU_DIV_EN
  assign start_div = in_valid & ~rst & md_idle & (ALUcontrol == ALU_DIVU);
`else
  assign start_div = 1'b0;
`endif

  assign stall = start_mul | start_div | md_busy;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_mul_i (start_mul),
`ifdef EX_ALU_DIV_EN
    .start_div_i (start_div),
`endif
    .a_i         (op_a),
    .b_i         (op_b),
    .idle_o      (md_idle),
    .busy_o      (md_busy),
    .hi_o        (hi),
    .lo_o        (lo)
  );

endmodule
